// File: rtl/sagu_miss_sched_pkg.sv
// Shared widths and FSM encoding for the store-AGU TLB-miss replay scheduler.
package sagu_miss_sched_pkg;

    localparam int ATTR_W   = 4;
    localparam int II_W     = 10;
    localparam int PAGE_LSB = 13;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WALK_REQ,
        ST_WALK_WAIT,
        ST_REPLAY,
        ST_DRAIN
    } state_t;

    // Entry packing is {page, thread, page offset, attr, II} so {page, thread} forms the top key bits.
    function automatic int entry_w(input int paddr_w);
        return paddr_w + ATTR_W + 1 + II_W;
    endfunction

endpackage

// File: rtl/sagu_miss_sched_if.sv
// AGU miss capture, page-walker handshake and replay/fault reporting bundle.
interface sagu_miss_sched_if
    import sagu_miss_sched_pkg::*;
#(
    parameter int PADDR_WIDTH = 44
);
    logic                   except;
    logic                   miss_en;
    logic [PADDR_WIDTH-1:0] miss_addr;
    logic [ATTR_W-1:0]      miss_attr;
    logic                   miss_thread;
    logic [II_W-1:0]        miss_II;
    logic                   full;
    logic                   walk_req;
    logic [PADDR_WIDTH-1:0] walk_addr;
    logic                   walk_thread;
    logic                   walk_ack;
    logic                   walk_done;
    logic                   walk_fault;
    logic                   mex_en;
    logic [PADDR_WIDTH-1:0] mex_addr;
    logic [ATTR_W-1:0]      mex_attr;
    logic                   bus_hold;
    logic [II_W-1:0]        replay_II;
    logic                   fault_en;
    logic [II_W-1:0]        fault_II;
    logic                   overflow_err;

    modport master (
        output except, miss_en, miss_addr, miss_attr, miss_thread, miss_II,
               walk_ack, walk_done, walk_fault,
        input  full, walk_req, walk_addr, walk_thread, mex_en, mex_addr, mex_attr,
               bus_hold, replay_II, fault_en, fault_II, overflow_err
    );

    modport slave (
        input  except, miss_en, miss_addr, miss_attr, miss_thread, miss_II,
               walk_ack, walk_done, walk_fault,
        output full, walk_req, walk_addr, walk_thread, mex_en, mex_addr, mex_attr,
               bus_hold, replay_II, fault_en, fault_II, overflow_err
    );
endinterface

// File: rtl/sagu_miss_fifo.sv
// Circular miss queue with simultaneous push/pop and a peek at the entry behind the head.
module sagu_miss_fifo
    import sagu_miss_sched_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 59,
    parameter int KEY_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [W-1:0]     i_data,
    output logic [W-1:0]     o_head,
    output logic [KEY_W-1:0] o_next_key,
    output logic             o_has_next,
    output logic             o_empty,
    output logic             o_full,
    output logic             o_ovf
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_head, r_tail;
    logic [CW-1:0] r_count;
    logic          r_full;

    logic          w_push, w_pop;
    logic [AW-1:0] w_head_p1;
    logic [CW-1:0] w_count_nxt;

    assign o_empty     = (r_count == '0);
    assign o_full      = r_full;
    assign w_pop       = i_pop && !o_empty;
    // A full queue still takes a push when the head leaves in the same cycle.
    assign w_push      = i_push && (!r_full || w_pop);
    assign o_ovf       = i_push && r_full && !w_pop;
    assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
    assign w_head_p1   = r_head + AW'(1);

    assign o_head      = r_mem[r_head];
    assign o_next_key  = r_mem[w_head_p1][W-1 -: KEY_W];
    assign o_has_next  = (r_count >= CW'(2));

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_tail] <= i_data;
    end

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
        end else begin
            if (w_push) r_tail <= r_tail + AW'(1);
            if (w_pop)  r_head <= w_head_p1;
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CW'(DEPTH));
        end
    end

endmodule

// File: rtl/sagu_miss_sched.sv
// Store-AGU TLB-miss replay scheduler: one walk per distinct page, in-order replay into the AGU.
module sagu_miss_sched
    import sagu_miss_sched_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int PADDR_WIDTH = 44
) (
    input  logic                 clk,
    input  logic                 rst,
    sagu_miss_sched_if.slave     io_if
);
    localparam int PG_W  = PADDR_WIDTH - PAGE_LSB;
    localparam int KEY_W = PG_W + 1;
    localparam int EW    = entry_w(PADDR_WIDTH);

    state_t             r_state, w_state_nxt;
    logic               r_page_vld;
    logic [KEY_W-1:0]   r_page_key;
    logic               r_fault_en;
    logic [II_W-1:0]    r_fault_II;
    logic               r_ovf;

    logic [EW-1:0]       w_entry, w_head;
    logic [KEY_W-1:0]    w_head_key, w_next_key;
    logic [PG_W-1:0]     w_head_page;
    logic [PAGE_LSB-1:0] w_head_off;
    logic                w_has_next, w_empty, w_full, w_fifo_ovf;
    logic                w_push, w_pop, w_walk_ok, w_walk_flt;
    logic                w_head_hit, w_next_hit, w_replay;

    assign w_entry = {io_if.miss_addr[PADDR_WIDTH-1:PAGE_LSB], io_if.miss_thread,
                      io_if.miss_addr[PAGE_LSB-1:0], io_if.miss_attr, io_if.miss_II};
    assign w_push  = io_if.miss_en && !io_if.except;

    sagu_miss_fifo #(.DEPTH(DEPTH), .W(EW), .KEY_W(KEY_W)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (io_if.except),
        .i_push     (w_push),
        .i_pop      (w_pop),
        .i_data     (w_entry),
        .o_head     (w_head),
        .o_next_key (w_next_key),
        .o_has_next (w_has_next),
        .o_empty    (w_empty),
        .o_full     (w_full),
        .o_ovf      (w_fifo_ovf)
    );

    assign w_head_key  = w_head[EW-1 -: KEY_W];
    assign w_head_page = w_head_key[KEY_W-1:1];
    assign w_head_off  = w_head[EW-KEY_W-1 -: PAGE_LSB];
    assign w_head_hit  = !w_empty && r_page_vld && (w_head_key == r_page_key);
    assign w_next_hit  = w_has_next && r_page_vld && (w_next_key == r_page_key);

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_walk_ok   = 1'b0;
        w_walk_flt  = 1'b0;
        case (r_state)
            ST_IDLE:      if (!w_empty) w_state_nxt = w_head_hit ? ST_REPLAY : ST_WALK_REQ;
            ST_WALK_REQ:  if (io_if.walk_ack) w_state_nxt = ST_WALK_WAIT;
            ST_WALK_WAIT: begin
                if (io_if.walk_done) begin
                    if (io_if.walk_fault) begin
                        w_walk_flt  = 1'b1;
                        w_pop       = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_walk_ok   = 1'b1;
                        w_state_nxt = ST_REPLAY;
                    end
                end
            end
            ST_REPLAY: begin
                w_pop       = 1'b1;
                w_state_nxt = w_next_hit ? ST_REPLAY : ST_IDLE;
            end
            ST_DRAIN:     if (io_if.walk_done) w_state_nxt = ST_IDLE;
            default:      w_state_nxt = ST_IDLE;
        endcase
        // A flush leaves any walk already handed to the walker to finish in DRAIN.
        if (io_if.except) begin
            w_pop      = 1'b0;
            w_walk_ok  = 1'b0;
            w_walk_flt = 1'b0;
            if ((((r_state == ST_WALK_WAIT) || (r_state == ST_DRAIN)) && !io_if.walk_done) ||
                ((r_state == ST_WALK_REQ) && io_if.walk_ack))
                w_state_nxt = ST_DRAIN;
            else
                w_state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_page_vld <= 1'b0;
            r_page_key <= '0;
            r_fault_en <= 1'b0;
            r_fault_II <= '0;
            r_ovf      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_fault_en <= w_walk_flt;
            r_ovf      <= r_ovf | w_fifo_ovf;
            if (w_walk_flt) r_fault_II <= w_head[II_W-1:0];
            if (io_if.except || w_walk_flt) begin
                r_page_vld <= 1'b0;
            end else if (w_walk_ok) begin
                r_page_vld <= 1'b1;
                r_page_key <= w_head_key;
            end
        end
    end

    assign w_replay           = (r_state == ST_REPLAY);
    assign io_if.full         = w_full;
    assign io_if.walk_req     = (r_state == ST_WALK_REQ);
    assign io_if.walk_addr    = io_if.walk_req ? {w_head_page, {PAGE_LSB{1'b0}}} : '0;
    assign io_if.walk_thread  = io_if.walk_req && w_head_key[0];
    assign io_if.mex_en       = w_replay && !io_if.except;
    assign io_if.bus_hold     = w_replay;
    assign io_if.mex_addr     = w_replay ? {w_head_page, w_head_off} : '0;
    assign io_if.mex_attr     = w_replay ? w_head[II_W +: ATTR_W] : '0;
    assign io_if.replay_II    = w_replay ? w_head[II_W-1:0] : '0;
    assign io_if.fault_en     = r_fault_en;
    assign io_if.fault_II     = r_fault_II;
    assign io_if.overflow_err = r_ovf;

endmodule

// File: tb/tb_sagu_miss_sched.sv
// Directed bench for sagu_miss_sched with a transaction-level queue/page model checked every cycle.
module tb_sagu_miss_sched;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sagu_miss_sched_if #(.PADDR_WIDTH(44)) bus();

    sagu_miss_sched #(.DEPTH(DEPTH), .PADDR_WIDTH(44)) dut (
        .clk   (clk),
        .rst   (rst),
        .io_if (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    endtask

    // Model: ordered list of accepted ops, the last good page, and pending one-cycle obligations.
    typedef struct {
        logic [43:0] addr;
        logic [3:0]  attr;
        logic        thr;
        logic [9:0]  ii;
    } ent_t;

    ent_t        mq[$];
    ent_t        f;
    bit          m_pvld, m_ovf, exp_mex, exp_flt, nx_mex, nx_flt, popped;
    bit          walk_out, drained;
    logic [30:0] m_page;
    logic        m_pthr;
    logic [9:0]  exp_flt_ii;
    int          n_walk = 0;

    function automatic bit hit(input ent_t e);
        return m_pvld && (e.addr[43:13] == m_page) && (e.thr == m_pthr);
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            mq.delete();
            m_pvld = 0; m_ovf = 0; exp_mex = 0; exp_flt = 0; walk_out = 0; drained = 0;
        end else begin
            chk("full", bus.full, 64'(mq.size() == DEPTH));
            chk("overflow_err", bus.overflow_err, 64'(m_ovf));
            chk("fault_en", bus.fault_en, 64'(exp_flt));
            if (exp_flt) chk("fault_II", bus.fault_II, exp_flt_ii);
            if (exp_mex && !bus.except) chk("mex_expected", bus.mex_en, 1);
            if (bus.except) chk("mex_in_except", bus.mex_en, 0);
            if (bus.mex_en) begin
                chk("mex_nonempty", 64'(mq.size() > 0), 1);
                if (mq.size() > 0) begin
                    f = mq[0];
                    chk("mex_addr", bus.mex_addr, f.addr);
                    chk("mex_attr", bus.mex_attr, f.attr);
                    chk("replay_II", bus.replay_II, f.ii);
                    chk("bus_hold", bus.bus_hold, 1);
                    chk("mex_page_hit", 64'(hit(f)), 1);
                end
            end else if (!bus.except) begin
                chk("bus_hold_idle", bus.bus_hold, 0);
            end
            if (bus.walk_req) begin
                chk("walk_nonempty", 64'(mq.size() > 0), 1);
                if (mq.size() > 0) begin
                    f = mq[0];
                    chk("walk_addr", bus.walk_addr, {f.addr[43:13], 13'h0});
                    chk("walk_thread", bus.walk_thread, f.thr);
                    chk("walk_distinct_page", 64'(hit(f)), 0);
                end
            end else begin
                chk("walk_addr_idle", bus.walk_addr, 0);
            end

            if (bus.walk_req && bus.walk_ack) n_walk++;
            if (bus.except) begin
                if (walk_out && bus.walk_done) begin
                    walk_out = 0; drained = 0;
                end else if (walk_out || (bus.walk_req && bus.walk_ack)) begin
                    walk_out = 1; drained = 1;
                end
                mq.delete();
                m_pvld = 0; exp_mex = 0; exp_flt = 0;
            end else begin
                popped = 0; nx_mex = 0; nx_flt = 0;
                if (bus.walk_done && walk_out) begin
                    walk_out = 0;
                    if (drained) drained = 0;
                    else if (mq.size() > 0) begin
                        f = mq[0];
                        if (bus.walk_fault) begin
                            nx_flt = 1; exp_flt_ii = f.ii; m_pvld = 0;
                            void'(mq.pop_front()); popped = 1;
                        end else begin
                            m_pvld = 1; m_page = f.addr[43:13]; m_pthr = f.thr; nx_mex = 1;
                        end
                    end
                end
                if (bus.walk_req && bus.walk_ack) walk_out = 1;
                if (bus.mex_en && mq.size() > 0) begin
                    void'(mq.pop_front()); popped = 1;
                    nx_mex = (mq.size() > 0) && hit(mq[0]);
                end
                if (bus.miss_en) begin
                    if (mq.size() < DEPTH || popped)
                        mq.push_back('{addr: bus.miss_addr, attr: bus.miss_attr,
                                       thr: bus.miss_thread, ii: bus.miss_II});
                    else
                        m_ovf = 1;
                end
                exp_mex = nx_mex; exp_flt = nx_flt;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [43:0] a, input logic [3:0] at, input logic t, input logic [9:0] ii);
        bus.miss_en = 1'b1; bus.miss_addr = a; bus.miss_attr = at; bus.miss_thread = t; bus.miss_II = ii;
        tick();
        bus.miss_en = 1'b0;
    endtask

    task automatic wait_walk_req(input string nm);
        int k = 0;
        while (!bus.walk_req && k < 30) begin
            tick();
            k++;
        end
        chk(nm, bus.walk_req, 1);
    endtask

    // Leaves the bench one cycle after walk_done, where a good walk shows its first replay.
    task automatic do_walk(input bit flt);
        wait_walk_req("walk_req_seen");
        bus.walk_ack = 1'b1; tick(); bus.walk_ack = 1'b0;
        tick(); tick();
        bus.walk_done = 1'b1; bus.walk_fault = flt; tick();
        bus.walk_done = 1'b0; bus.walk_fault = 1'b0;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_walk_req"}, bus.walk_req, 0);
        chk({nm, "_walk_addr"}, bus.walk_addr, 0);
        chk({nm, "_mex_en"}, bus.mex_en, 0);
        chk({nm, "_bus_hold"}, bus.bus_hold, 0);
        chk({nm, "_mex_addr"}, bus.mex_addr, 0);
        chk({nm, "_replay_II"}, bus.replay_II, 0);
        chk({nm, "_fault_en"}, bus.fault_en, 0);
        chk({nm, "_fault_II"}, bus.fault_II, 0);
        chk({nm, "_full"}, bus.full, 0);
        chk({nm, "_overflow_err"}, bus.overflow_err, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        bus.except = 0; bus.miss_en = 0; bus.miss_addr = '0; bus.miss_attr = '0;
        bus.miss_thread = 0; bus.miss_II = '0; bus.walk_ack = 0; bus.walk_done = 0; bus.walk_fault = 0;
        tick(); tick();
        chk_all_zero("reset");
        rst = 1'b0;
        tick();

        // 1: single miss, 2-cycle walk_req latency, 1-cycle replay latency
        push(44'h123_4567_8ABC, 4'h3, 1'b0, 10'h005);
        chk("t1_no_walk_yet", bus.walk_req, 0);
        tick();
        chk("t1_walk_req", bus.walk_req, 1);
        chk("t1_walk_addr", bus.walk_addr, 44'h123_4567_8000);
        chk("t1_walk_thread", bus.walk_thread, 0);
        do_walk(1'b0);
        chk("t1_mex_en", bus.mex_en, 1);
        chk("t1_mex_addr", bus.mex_addr, 44'h123_4567_8ABC);
        chk("t1_bus_hold", bus.bus_hold, 1);
        chk("t1_replay_II", bus.replay_II, 10'h005);
        tick();
        chk("t1_mex_done", bus.mex_en, 0);

        // 2: three ops sharing a page share one walk, fourth page walks separately
        w0 = n_walk;
        push(44'h000_1000_2010, 4'h1, 1'b1, 10'h021);
        push(44'h000_1000_2020, 4'h2, 1'b1, 10'h022);
        push(44'h000_1000_2030, 4'h3, 1'b1, 10'h023);
        push(44'h000_1000_4040, 4'h4, 1'b1, 10'h024);
        do_walk(1'b0);
        chk("t2_mex0", bus.mex_en, 1); chk("t2_ii0", bus.replay_II, 10'h021);
        tick(); chk("t2_mex1", bus.mex_en, 1); chk("t2_ii1", bus.replay_II, 10'h022);
        tick(); chk("t2_mex2", bus.mex_en, 1); chk("t2_ii2", bus.replay_II, 10'h023);
        tick(); chk("t2_gap", bus.mex_en, 0);
        do_walk(1'b0);
        chk("t2_ii3", bus.replay_II, 10'h024);
        tick();
        chk("t2_walk_count", 64'(n_walk - w0), 2);

        // 3: faulted walk reports II and the next entry walks
        push(44'h0AB_CDE0_0100, 4'h5, 1'b0, 10'h3FF);
        push(44'h0AB_CDE2_0200, 4'h6, 1'b0, 10'h011);
        do_walk(1'b1);
        chk("t3_fault_en", bus.fault_en, 1);
        chk("t3_fault_II", bus.fault_II, 10'h3FF);
        chk("t3_no_mex", bus.mex_en, 0);
        tick();
        chk("t3_fault_pulse", bus.fault_en, 0);
        wait_walk_req("t3_next_walk");
        chk("t3_next_walk_addr", bus.walk_addr, 44'h0AB_CDE2_0000);
        do_walk(1'b0);
        chk("t3_replay_II", bus.replay_II, 10'h011);
        tick();

        // 4: overflow drops an op; push during a replay pop is accepted when full
        for (int i = 0; i < 4; i++)
            push(44'h00F_0000_0000 + 44'(i * 16), 4'h7, 1'b0, 10'h040 + 10'(i));
        chk("t4_full", bus.full, 1);
        push(44'h00F_0000_0050, 4'h7, 1'b0, 10'h044);
        chk("t4_overflow", bus.overflow_err, 1);
        chk("t4_still_full", bus.full, 1);
        do_walk(1'b0);
        chk("t4_ii40", bus.replay_II, 10'h040);
        bus.miss_en = 1'b1; bus.miss_addr = 44'h00F_0000_0060; bus.miss_II = 10'h045;
        tick();
        bus.miss_en = 1'b0;
        chk("t4_full_after_pp", bus.full, 1);
        chk("t4_ii41", bus.replay_II, 10'h041);
        tick(); chk("t4_ii42", bus.replay_II, 10'h042);
        tick(); chk("t4_ii43", bus.replay_II, 10'h043);
        tick(); chk("t4_ii45", bus.replay_II, 10'h045); chk("t4_mex45", bus.mex_en, 1);
        tick(); chk("t4_end", bus.mex_en, 0);

        // 5: flush during a walk drains the result, then the page walks again
        push(44'h300_0000_2100, 4'h8, 1'b1, 10'h051);
        push(44'h300_0000_2200, 4'h8, 1'b1, 10'h052);
        push(44'h300_0000_2300, 4'h8, 1'b1, 10'h053);
        wait_walk_req("t5_walk");
        bus.walk_ack = 1'b1; tick(); bus.walk_ack = 1'b0;
        tick();
        bus.except = 1'b1; tick(); bus.except = 1'b0;
        chk("t5_full_clr", bus.full, 0);
        chk("t5_drain_no_req", bus.walk_req, 0);
        tick();
        bus.walk_done = 1'b1; tick(); bus.walk_done = 1'b0;
        chk("t5_no_mex", bus.mex_en, 0);
        chk("t5_no_fault", bus.fault_en, 0);
        tick();
        chk("t5_idle", bus.walk_req, 0);
        push(44'h300_0000_2400, 4'h9, 1'b1, 10'h054);
        tick();
        chk("t5_rewalk", bus.walk_req, 1);
        chk("t5_rewalk_addr", bus.walk_addr, 44'h300_0000_2000);
        do_walk(1'b0);
        chk("t5_replay_II", bus.replay_II, 10'h054);
        tick();

        // 6: reset mid-walk clears everything including sticky overflow
        push(44'h555_0000_1000, 4'h7, 1'b0, 10'h066);
        tick();
        chk("t6_walk_req", bus.walk_req, 1);
        rst = 1'b1;
        tick();
        chk_all_zero("t6_rst");
        rst = 1'b0;
        tick(); tick();
        chk("t6_stays_idle", bus.walk_req, 0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sagu_miss_sched.md
Name: sagu_miss_sched

Overview:
- Store-AGU TLB-miss replay scheduler, sitting beside sagu.
- Captures store ops that raised tlbMiss and queues them in order.
- Issues one page-walk request per distinct page; on walk completion replays each queued op into the AGU through the mex_en/mex_addr/mex_attr path, asserting bus_hold for the replay cycle.
- Reports walk faults against the op's II number.

Parameters:
DEPTH, 4, miss queue entries (power of 2, 2..16)
PADDR_WIDTH, 44, address width of queued/replayed addresses

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
except  in  1  pipeline flush
miss_en  in  1  AGU reports tlbMiss this cycle
miss_addr  in  44  faulting virtual address (cmplxAddr[43:0])
miss_attr  in  4  op attr
miss_thread  in  1  op thread
miss_II  in  10  op II number
full  out  1  queue full; upstream must not issue stores
walk_req  out  1  page-walk request valid
walk_addr  out  44  {page[43:13],13'b0} of head entry
walk_thread  out  1  thread of head entry
walk_ack  in  1  walker accepted request
walk_done  in  1  walk finished, TLB filled
walk_fault  in  1  qualifies walk_done: translation faulted
mex_en  out  1  replay strobe to AGU
mex_addr  out  44  replay address
mex_attr  out  4  replay attr
bus_hold  out  1  blocks regular AGU issue
replay_II  out  10  II of replayed op
fault_en  out  1  one-cycle fault report
fault_II  out  10  II of faulted op
overflow_err  out  1  sticky: miss_en accepted while full with no pop

Behaviour:
- Reset: all outputs 0; queue empty; state IDLE; page_vld=0.
- Queue: circular FIFO, head/tail pointers plus count (log2(DEPTH)+1 bits). Pointers wrap mod DEPTH.
- Push on miss_en, into entry {addr, attr, thread, II}.
- Push and pop in the same cycle are both allowed; a push is accepted when full only if a pop occurs that cycle.
- Push when full with no pop: entry is dropped and overflow_err is set (sticky until rst).
- full = (count==DEPTH), registered.
- Page register {page_vld, page[43:13], thread} records the last successful walk.
- States:
  - IDLE
    - empty -> stay.
    - Head matches page register (page_vld, same page and thread) -> REPLAY.
    - Otherwise -> WALK_REQ.
  - WALK_REQ: walk_req=1, holding addr/thread stable. On walk_ack -> WALK_WAIT, same cycle.
  - WALK_WAIT: wait for walk_done.
    - walk_fault=1: fault_en=1 next cycle with fault_II=head II; pop head; page_vld=0 -> IDLE.
    - Otherwise: page register loaded -> REPLAY.
  - REPLAY (1 cycle): mex_en=1, bus_hold=1, mex_addr/mex_attr/replay_II from head; pop head.
    - Next head matches page register -> REPLAY again (back-to-back).
    - Otherwise -> IDLE.
  - DRAIN: entered when except arrives in WALK_REQ after walk_ack, or in WALK_WAIT. Waits for walk_done, discards the result (no fault_en, page_vld stays 0) -> IDLE.
- mex_en, bus_hold and walk_req are combinational from state and head; fault_en is registered.
- except (any state): queue cleared and page_vld=0 the same edge.
  - From WALK_WAIT, or WALK_REQ with walk_ack in the same cycle: -> DRAIN.
  - Otherwise: -> IDLE.
  - A miss_en coincident with except is dropped.
  - mex_en is suppressed in the except cycle.
- walk_done outside WALK_WAIT/DRAIN is ignored.
- Latency, miss_en to walk_req: 2 cycles (push edge, IDLE evaluates, WALK_REQ).
- Latency, walk_done to mex_en: 1 cycle.
- rst mid-walk: state IDLE immediately. The walker is reset by the same rst, so no DRAIN.

Decomposition:
- struct.sv gets the state encodings (`smsched_IDLE .. `smsched_DRAIN) and the entry field layout (`smsched_addr, `smsched_attr, `smsched_thr, `smsched_II, entry width 59).
- One sub-module, sagu_miss_fifo: parameterised storage, head/tail/count, full/empty, simultaneous push/pop.

Test Plan:
1. Single miss: miss_en, addr=44'h123_4567_8ABC, thread 0, II=10'h05 -> walk_req 2 cycles later, walk_addr=44'h123_4567_8000. Then walk_ack, walk_done 3 cycles later -> mex_en one cycle later with addr 44'h123_4567_8ABC, bus_hold=1, replay_II=5.
2. Three misses in the same page 0x1000_2000 (offsets 0x10, 0x20, 0x30), then a fourth in page 0x1000_4000 -> exactly 2 walk_req. After the first walk_done, three consecutive mex_en cycles in order.
3. walk_done with walk_fault=1 for head II=0x3FF -> fault_en 1 cycle, fault_II=0x3FF, no mex_en, page_vld=0, next entry walks.
4. Fill DEPTH=4 entries, then miss_en with no pop -> full=1, overflow_err=1, and the entry is not replayed. Then miss_en in the same cycle as a REPLAY pop -> accepted, count stays 4.
5. except during WALK_WAIT with 3 queued -> queue empty next cycle, state DRAIN. walk_done then produces no mex_en/fault_en and page_vld=0. A new miss afterwards walks again.
6. rst asserted in WALK_REQ -> next cycle all outputs 0, full=0, overflow_err=0.
